reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Parametrised power-on and soft reset sequencer for the design's single clock domain.
- Accepts an asynchronous active-low board reset and a synchronous soft-reset request.
- Drives NUM_OUTS active-high reset outputs, released one at a time in index order.
- Each release waits a minimum gap and the previous stage's ready acknowledge, with a timeout watchdog. Sits at the top level and feeds block resets.

Parameters:
NUM_OUTS, 4, number of sequenced reset outputs (>=2)
SYNC_STAGES, 2, flops in rst_n deassertion synchroniser (>=2)
HOLD_CYCLES, 10, cycles all outputs stay asserted after synchronised release (>=1)
STAGE_GAP, 16, minimum cycles between consecutive stage releases (>=1)
TIMEOUT, 1024, cycles to wait for stage_ready before flagging fault (>STAGE_GAP)
CNT_W, 16, counter width; TIMEOUT-1 and HOLD_CYCLES-1 must fit

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset; assertion async, deassertion synchronised internally
soft_rst_req  input  1  synchronous level request to re-run the full sequence
stage_ready  input  NUM_OUTS  stage_ready[i] high = block behind reset_out[i] has come up
reset_out  output  NUM_OUTS  active-high resets; bit i released in order 0..NUM_OUTS-1
done  output  1  high once all stages released and last stage ready
fault  output  1  sticky: some stage missed its ready within TIMEOUT
fault_stage  output  max(1,$clog2(NUM_OUTS))  index of first stage that timed out

Behaviour:
- rst_n low, async: reset_out=all ones, done=0, fault=0, fault_stage=0, sync chain=0, cnt=0, state=HOLD, idx=0. Applies mid-sequence too.
- Synchroniser: SYNC_STAGES flops shift in 1 after rst_n rises. rst_sync is high after edge SYNC_STAGES, counting edge 1 as the first edge with rst_n high. Until then the FSM is frozen in HOLD.
- All outputs are registered; no combinational paths from inputs to outputs.
- States: HOLD, WAIT (stage idx released, awaiting next), DONE.
- HOLD, rst_sync=1, soft_rst_req=0:
  - if cnt==HOLD_CYCLES-1: clear reset_out[0], idx=0, cnt=0, go WAIT.
  - else cnt++.
  - Defaults: reset_out[0] falls after edge 12.
- WAIT(idx):
  - Release condition: stage_ready[idx]=1 and cnt>=STAGE_GAP-1.
    - If idx<NUM_OUTS-1: clear reset_out[idx+1], idx++, cnt=0.
    - If idx==NUM_OUTS-1: set done=1, go DONE.
  - Else if cnt==TIMEOUT-1:
    - Set fault=1; if fault was 0, set fault_stage=idx.
    - Proceed as if ready arrived: same release or done action.
  - Else cnt++.
  - With stage_ready tied high, consecutive releases are exactly STAGE_GAP edges apart.
  - Defaults: reset_out[1..3] fall after edges 28, 44, 60; done rises after edge 76.
- stage_ready bits of stages not yet released are ignored. A ready that drops after release has no effect.
- DONE: hold outputs; only soft_rst_req or rst_n leave.
- soft_rst_req=1 (any state, rst_sync=1), next edge: reset_out=all ones, done=0, cnt=0, idx=0, state=HOLD.
  - cnt stays 0 while the request is held.
  - HOLD counting starts on the first edge with the request low, giving the same HOLD_CYCLES + gap timing as power-up.
  - fault and fault_stage are not cleared by soft reset; only rst_n clears them.
- soft_rst_req has priority over a release or timeout on the same edge.
- Released bits never re-assert except via soft reset or rst_n. Outputs change only on clk edges, except async rst_n assertion.

Test Plan:
- Power-up, defaults, stage_ready=4'b1111, rst_n rises before edge 1 → reset_out[0..3] fall after edges 12/28/44/60; done=1 after edge 76; fault=0.
- rst_n pulsed low for 3 ns mid-cycle at edge 40 → reset_out=4'b1111 and done=0 immediately (async). Sequence restarts; reset_out[0] falls 12 edges after rst_n returns high.
- stage_ready[1] held low, others high → reset_out[2] falls after edge 28+1024=1052; fault=1, fault_stage=1; done still rises after the remaining gaps.
- stage_ready[0] rises at edge 50 → reset_out[1] falls after edge 50 (not 28); later gaps remain 16.
- soft_rst_req high edges 100–104 in DONE → reset_out=4'b1111 after edge 100; reset_out[0] falls after edge 115 (104+1+10); fault unchanged.
- soft_rst_req asserted on the same edge as a stage release → release suppressed; all outputs asserted next cycle.

Source files
------------

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//   Power-on / soft reset sequencer. It holds every downstream block in reset,
//   then releases the block resets one at a time in index order. Each release
//   waits for a minimum gap and for the previous stage's ready acknowledge. A
//   watchdog moves the sequence on if an acknowledge never arrives, and it
//   records the first stage that timed out.
//
// Ports
//   clk          : system clock; all logic uses the rising edge
//   rst_n        : board reset, active low. Assertion is asynchronous.
//                  Deassertion passes through an internal synchroniser.
//   soft_rst_req : synchronous level request to re-run the whole sequence
//   stage_ready  : [i] high once the block behind reset_out[i] is up
//   reset_out    : active-high block resets, released in order 0..NUM_OUTS-1
//   done         : high once all stages are released and the last is ready
//   fault        : sticky flag; some stage missed its ready within TIMEOUT
//   fault_stage  : index of the first stage that timed out
// -----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int NUM_OUTS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 10,
    parameter int STAGE_GAP   = 16,
    parameter int TIMEOUT     = 1024,
    parameter int CNT_W       = 16,
    localparam int IDX_W      = (NUM_OUTS > 2) ? $clog2(NUM_OUTS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                soft_rst_req,
    input  logic [NUM_OUTS-1:0] stage_ready,
    output logic [NUM_OUTS-1:0] reset_out,
    output logic                done,
    output logic                fault,
    output logic [IDX_W-1:0]    fault_stage
);

    typedef enum logic [1:0] {ST_HOLD, ST_WAIT, ST_DONE} state_t;

    // ---------------- rst_n deassertion synchroniser ----------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rst_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q[0] <= 1'b0;
        else        sync_q[0] <= 1'b1;
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) sync_q[gi] <= 1'b0;
                else        sync_q[gi] <= sync_q[gi-1];
            end
        end
    endgenerate

    assign rst_sync = sync_q[SYNC_STAGES-1];

    // ---------------- sequencer state ----------------
    state_t               state_q,       state_d;
    logic [CNT_W-1:0]     cnt_q,         cnt_d;
    logic [IDX_W-1:0]     idx_q,         idx_d;
    logic [NUM_OUTS-1:0]  reset_out_q,   reset_out_d;
    logic                 done_q,        done_d;
    logic                 fault_q,       fault_d;
    logic [IDX_W-1:0]     fault_stage_q, fault_stage_d;
    // Soft request seen on the previous edge. HOLD does not count on the first
    // edge after the request drops. This gives the request-drop to release
    // delay of one settle cycle plus HOLD_CYCLES.
    logic                 soft_q,        soft_d;

    logic [IDX_W-1:0]     idx_inc;
    logic                 ready_ok;
    logic                 timed_out;

    assign idx_inc   = idx_q + 1'b1;
    assign ready_ok  = stage_ready[idx_q] && (cnt_q >= CNT_W'(STAGE_GAP - 1));
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_HOLD;
            cnt_q         <= '0;
            idx_q         <= '0;
            reset_out_q   <= '1;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
            fault_stage_q <= '0;
            soft_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            reset_out_q   <= reset_out_d;
            done_q        <= done_d;
            fault_q       <= fault_d;
            fault_stage_q <= fault_stage_d;
            soft_q        <= soft_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        reset_out_d   = reset_out_q;
        done_d        = done_q;
        fault_d       = fault_q;
        fault_stage_d = fault_stage_q;
        soft_d        = rst_sync & soft_rst_req;

        if (!rst_sync) begin
            // The sequencer stays frozen in HOLD until the synchroniser releases.
        end else if (soft_rst_req) begin
            // A soft request wins over any release or timeout on the same edge.
            state_d     = ST_HOLD;
            cnt_d       = '0;
            idx_d       = '0;
            reset_out_d = '1;
            done_d      = 1'b0;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    if (soft_q) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                        reset_out_d[0] = 1'b0;
                        idx_d          = '0;
                        cnt_d          = '0;
                        state_d        = ST_WAIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (ready_ok || timed_out) begin
                        // When the timeout fires, the sequence still moves on.
                        // Only the first offending stage is recorded.
                        if (!ready_ok) begin
                            fault_d = 1'b1;
                            if (!fault_q) fault_stage_d = idx_q;
                        end
                        if (idx_q == IDX_W'(NUM_OUTS - 1)) begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            reset_out_d[idx_inc] = 1'b0;
                            idx_d                = idx_inc;
                            cnt_d                = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    // ST_DONE: hold the outputs until a soft reset or rst_n.
                end
            endcase
        end
    end

    assign reset_out   = reset_out_q;
    assign done        = done_q;
    assign fault       = fault_q;
    assign fault_stage = fault_stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//   Directed bench for reset_sequencer with default parameters. Edge numbers
//   count rising clock edges from the first edge with rst_n high. The edge
//   counter restarts at every rst_n release. Outputs are sampled 1 ns after an
//   edge.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       soft_rst_req;
    logic [3:0] stage_ready;
    logic [3:0] reset_out;
    logic       done;
    logic       fault;
    logic [1:0] fault_stage;

    int n_cmp = 0;
    int n_bad = 0;
    int cur   = 0;

    reset_sequencer #(
        .NUM_OUTS(4), .SYNC_STAGES(2), .HOLD_CYCLES(10),
        .STAGE_GAP(16), .TIMEOUT(1024), .CNT_W(16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .soft_rst_req (soft_rst_req),
        .stage_ready  (stage_ready),
        .reset_out    (reset_out),
        .done         (done),
        .fault        (fault),
        .fault_stage  (fault_stage)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hold rst_n low for a few edges, then release it at a falling edge.
    // The next rising edge is edge 1.
    task automatic por();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cur = 0;
    endtask

    // Advance to 1 ns after edge k.
    task automatic go(input int k);
        while (cur < k) begin
            @(posedge clk);
            cur++;
        end
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        soft_rst_req = 1'b0;
        stage_ready  = 4'b1111;

        // ---- A: power-up with default timing, then a soft reset in DONE ----
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_reset_out", reset_out, 4'b1111);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_fault_stage", fault_stage, 0);
        por();
        go(11);  chk("A_e11", reset_out, 4'b1111);
        go(12);  chk("A_e12", reset_out, 4'b1110);
        go(27);  chk("A_e27", reset_out, 4'b1110);
        go(28);  chk("A_e28", reset_out, 4'b1100);
        go(44);  chk("A_e44", reset_out, 4'b1000);
        go(60);  chk("A_e60", reset_out, 4'b0000);
        go(75);  chk("A_e75_done", done, 0);
        go(76);  chk("A_e76_done", done, 1);
        chk("A_fault", fault, 0);
        go(99);  soft_rst_req = 1'b1;
        go(100); chk("A_soft_e100", reset_out, 4'b1111);
        chk("A_soft_done", done, 0);
        go(104); soft_rst_req = 1'b0;
        go(114); chk("A_soft_e114", reset_out, 4'b1111);
        go(115); chk("A_soft_e115", reset_out, 4'b1110);
        go(131); chk("A_soft_e131", reset_out, 4'b1100);
        chk("A_soft_fault", fault, 0);

        // ---- B: stage 1 never ready, so the watchdog fires ----
        stage_ready = 4'b1101;
        por();
        go(28);   chk("B_e28", reset_out, 4'b1100);
        go(44);   chk("B_e44", reset_out, 4'b1100);
        go(1051); chk("B_e1051", reset_out, 4'b1100);
        chk("B_e1051_fault", fault, 0);
        go(1052); chk("B_e1052", reset_out, 4'b1000);
        chk("B_fault", fault, 1);
        chk("B_fault_stage", fault_stage, 1);
        go(1068); chk("B_e1068", reset_out, 4'b0000);
        go(1083); chk("B_e1083_done", done, 0);
        go(1084); chk("B_e1084_done", done, 1);
        go(1089); soft_rst_req = 1'b1;
        go(1090); soft_rst_req = 1'b0;
        chk("B_soft_reset_out", reset_out, 4'b1111);
        chk("B_soft_done", done, 0);
        chk("B_soft_fault", fault, 1);
        chk("B_soft_fault_stage", fault_stage, 1);

        // ---- C: short rst_n pulse mid-sequence is asynchronous ----
        stage_ready = 4'b1111;
        por();
        go(40); chk("C_e40", reset_out, 4'b1100);
        #2 rst_n = 1'b0;
        #1;
        chk("C_async_reset_out", reset_out, 4'b1111);
        chk("C_async_done", done, 0);
        chk("C_async_fault", fault, 0);
        chk("C_async_fault_stage", fault_stage, 0);
        #2 rst_n = 1'b1;
        cur = 0;
        go(11); chk("C_e11", reset_out, 4'b1111);
        go(12); chk("C_e12", reset_out, 4'b1110);

        // ---- D: stage 0 ready arrives late, at edge 50 ----
        stage_ready = 4'b1110;
        por();
        go(28); chk("D_e28", reset_out, 4'b1110);
        go(49); chk("D_e49", reset_out, 4'b1110);
        stage_ready = 4'b1111;
        go(50); chk("D_e50", reset_out, 4'b1100);
        go(65); chk("D_e65", reset_out, 4'b1100);
        go(66); chk("D_e66", reset_out, 4'b1000);
        go(82); chk("D_e82", reset_out, 4'b0000);
        go(97); chk("D_e97_done", done, 0);
        go(98); chk("D_e98_done", done, 1);
        chk("D_fault", fault, 0);

        // ---- E: soft request on the same edge as a release ----
        por();
        go(27); chk("E_e27", reset_out, 4'b1110);
        soft_rst_req = 1'b1;
        go(28); chk("E_e28", reset_out, 4'b1111);
        soft_rst_req = 1'b0;
        go(38); chk("E_e38", reset_out, 4'b1111);
        go(39); chk("E_e39", reset_out, 4'b1110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
